// File: rtl/lif_bank.sv
// Bank of leaky integrate-and-fire neurons updated in parallel on each valid timestep.
// Each channel has a saturating membrane voltage, a refractory counter and a selectable post-spike reset.
module lif_bank #(
  parameter int N_CH       = 4,
  parameter int V_SIZE     = 8,
  parameter int THRESHOLD  = 64,
  parameter int V_LEAK     = 1,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [N_CH*V_SIZE-1:0]   spike_in,
  output logic                     out_valid,
  output logic [N_CH-1:0]          spike_out
);

  localparam int VW   = V_SIZE - 1;
  localparam int RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int VMAX = (1 << VW) - 1;

  localparam logic signed [V_SIZE:0] VMAX_S   = (V_SIZE + 1)'(VMAX);
  localparam logic signed [V_SIZE:0] LEAK_S   = (V_SIZE + 1)'(V_LEAK);
  localparam logic [VW-1:0]          THR_V    = VW'(THRESHOLD);
  localparam logic [RW-1:0]          REFRAC_V = RW'(REFRAC);

  logic [N_CH*VW-1:0] volt_r;
  logic [N_CH*VW-1:0] volt_nxt;
  logic [N_CH*RW-1:0] refr_r;
  logic [N_CH*RW-1:0] refr_nxt;
  logic [N_CH-1:0]    spike_nxt;

  logic [VW-1:0]          v_cur;
  logic [RW-1:0]          r_cur;
  logic [V_SIZE-1:0]      x_cur;
  logic signed [V_SIZE:0] sum;
  logic [VW-1:0]          n_val;

  // Next-state computation for every channel: integrate, saturate, leak, fire, refractory.
  always_comb begin
    volt_nxt  = volt_r;
    refr_nxt  = refr_r;
    spike_nxt = '0;
    v_cur     = '0;
    r_cur     = '0;
    x_cur     = '0;
    sum       = '0;
    n_val     = '0;
    for (int c = 0; c < N_CH; c++) begin
      v_cur = volt_r[c*VW +: VW];
      r_cur = refr_r[c*RW +: RW];
      x_cur = spike_in[c*V_SIZE +: V_SIZE];
      // Two extra bits keep v + x exact: unsigned v zero-extended, x sign-extended.
      sum   = $signed({2'b00, v_cur}) + $signed({x_cur[V_SIZE-1], x_cur});
      n_val = '0;
      if (r_cur != '0) begin
        refr_nxt[c*RW +: RW] = r_cur - RW'(1);
      end else begin
        if (sum > VMAX_S) begin
          n_val = VW'(VMAX);
        end else if (sum > LEAK_S) begin
          n_val = VW'(sum - LEAK_S);
        end else begin
          n_val = '0;
        end
        if (n_val >= THR_V) begin
          spike_nxt[c]         = 1'b1;
          refr_nxt[c*RW +: RW] = REFRAC_V;
          if (RESET_MODE != 0) begin
            volt_nxt[c*VW +: VW] = n_val - THR_V;
          end else begin
            volt_nxt[c*VW +: VW] = '0;
          end
        end else begin
          volt_nxt[c*VW +: VW] = n_val;
        end
      end
    end
  end

  // Channel state and registered spike flags; state only advances on accepted timesteps.
  always_ff @(posedge clk) begin
    if (rst) begin
      volt_r    <= '0;
      refr_r    <= '0;
      out_valid <= 1'b0;
      spike_out <= '0;
    end else if (in_valid) begin
      volt_r    <= volt_nxt;
      refr_r    <= refr_nxt;
      out_valid <= 1'b1;
      spike_out <= spike_nxt;
    end else begin
      out_valid <= 1'b0;
      spike_out <= '0;
    end
  end

endmodule

// File: tb/tb_lif_bank.sv
// Self-checking bench for lif_bank: three parameterisations share one stimulus stream
// and are compared every timestep against an integer-arithmetic neuron model.
module tb_lif_bank;
  localparam int N_CH = 4;
  localparam int VW   = 7;
  localparam int ND   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] spike_in;

  logic [ND-1:0]        ov;
  logic [ND-1:0][3:0]   so;
  logic [ND-1:0][27:0]  dv;

  always #5 clk = ~clk;

  lif_bank dut_a (.clk(clk), .rst(rst), .in_valid(in_valid), .spike_in(spike_in),
                  .out_valid(ov[0]), .spike_out(so[0]));
  lif_bank #(.THRESHOLD(127)) dut_b (.clk(clk), .rst(rst), .in_valid(in_valid),
                  .spike_in(spike_in), .out_valid(ov[1]), .spike_out(so[1]));
  lif_bank #(.RESET_MODE(1), .REFRAC(0)) dut_c (.clk(clk), .rst(rst), .in_valid(in_valid),
                  .spike_in(spike_in), .out_valid(ov[2]), .spike_out(so[2]));

  assign dv[0] = dut_a.volt_r;
  assign dv[1] = dut_b.volt_r;
  assign dv[2] = dut_c.volt_r;

  // Behavioural model state: plain integers per instance and channel.
  int       mv [ND][N_CH];
  int       mr [ND][N_CH];
  bit       ev [ND];
  bit [3:0] es [ND];
  int       p_thr  [ND] = '{64, 127, 64};
  int       p_ref  [ND] = '{2, 2, 0};
  int       p_mode [ND] = '{0, 0, 1};

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [27:0] packv(input int d);
    logic [27:0] p;
    p = '0;
    for (int c = 0; c < N_CH; c++) p[c*VW +: VW] = 7'(mv[d][c]);
    return p;
  endfunction

  task automatic step(input bit r_in, input bit v_in, input logic [31:0] x_in);
    int x, s, n;
    @(negedge clk);
    rst = r_in; in_valid = v_in; spike_in = x_in;
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      es[d] = 4'b0000;
      ev[d] = 1'b0;
      if (r_in) begin
        for (int c = 0; c < N_CH; c++) begin mv[d][c] = 0; mr[d][c] = 0; end
      end else if (v_in) begin
        ev[d] = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
          x = $signed(x_in[c*8 +: 8]);
          if (mr[d][c] > 0) begin
            mr[d][c]--;
          end else begin
            s = mv[d][c] + x;
            if (s > 127) n = 127;
            else n = (s - 1 < 0) ? 0 : s - 1;
            if (n >= p_thr[d]) begin
              es[d][c] = 1'b1;
              mr[d][c] = p_ref[d];
              mv[d][c] = (p_mode[d] != 0) ? n - p_thr[d] : 0;
            end else begin
              mv[d][c] = n;
            end
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 32'h0);
      for (int d = 0; d < ND; d++) begin
        n_chk++;
        if ({ov[d], so[d], dv[d]} !== {1'b0, 4'b0000, 28'h0}) begin
          n_fail++;
          $display("FAIL reset dut%0d: got valid=%b spk=%b v=%h, want 0/0/0", d, ov[d], so[d], dv[d]);
        end
      end
    end
  endtask

  task automatic test_integrate();
    int exp_v [7] = '{19, 38, 57, 0, 0, 0, 19};
    bit exp_s [7] = '{0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 32'h0000_0014);
      n_chk++;
      if ({so[0][0], dv[0][6:0]} !== {exp_s[i], 7'(exp_v[i])}) begin
        n_fail++;
        $display("FAIL integrate step %0d: got spk=%b v=%0d, want spk=%b v=%0d",
                 i + 1, so[0][0], dv[0][6:0], exp_s[i], exp_v[i]);
      end
      for (int d = 0; d < ND; d++) begin
        n_chk++;
        if ({ov[d], so[d], dv[d]} !== {ev[d], es[d], packv(d)}) begin
          n_fail++;
          $display("FAIL integrate_model dut%0d: got %b/%b/%h, want %b/%b/%h",
                   d, ov[d], so[d], dv[d], ev[d], es[d], packv(d));
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] xs [6] = '{8'd100, 8'd100, 8'd0, 8'd0, 8'd11, 8'h80};
    int exp_v [6] = '{99, 0, 0, 0, 10, 0};
    bit exp_s [6] = '{0, 1, 0, 0, 0, 0};
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, {24'h0, xs[i]});
      n_chk++;
      if ({so[1][0], dv[1][6:0]} !== {exp_s[i], 7'(exp_v[i])}) begin
        n_fail++;
        $display("FAIL saturate step %0d: got spk=%b v=%0d, want spk=%b v=%0d",
                 i + 1, so[1][0], dv[1][6:0], exp_s[i], exp_v[i]);
      end
      for (int d = 0; d < ND; d++) begin
        n_chk++;
        if ({ov[d], so[d], dv[d]} !== {ev[d], es[d], packv(d)}) begin
          n_fail++;
          $display("FAIL saturate_model dut%0d: got %b/%b/%h, want %b/%b/%h",
                   d, ov[d], so[d], dv[d], ev[d], es[d], packv(d));
        end
      end
    end
  endtask

  task automatic test_reset_mode();
    logic [7:0] xs [2] = '{8'd70, 8'd60};
    int exp_v [2] = '{5, 0};
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, {24'h0, xs[i]});
      n_chk++;
      if ({so[2][0], dv[2][6:0]} !== {1'b1, 7'(exp_v[i])}) begin
        n_fail++;
        $display("FAIL reset_mode step %0d: got spk=%b v=%0d, want spk=1 v=%0d",
                 i + 1, so[2][0], dv[2][6:0], exp_v[i]);
      end
      for (int d = 0; d < ND; d++) begin
        n_chk++;
        if ({ov[d], so[d], dv[d]} !== {ev[d], es[d], packv(d)}) begin
          n_fail++;
          $display("FAIL reset_mode_model dut%0d: got %b/%b/%h, want %b/%b/%h",
                   d, ov[d], so[d], dv[d], ev[d], es[d], packv(d));
        end
      end
    end
  endtask

  task automatic test_gaps();
    bit         vs [6] = '{1, 1, 0, 0, 1, 1};
    logic [7:0] xs [6] = '{8'd70, 8'd50, 8'd50, 8'd50, 8'd50, 8'd20};
    int exp_v [6] = '{0, 0, 0, 0, 0, 19};
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, vs[i], {24'h0, xs[i]});
      n_chk++;
      if ({ov[0], dv[0][6:0]} !== {vs[i], 7'(exp_v[i])}) begin
        n_fail++;
        $display("FAIL gaps step %0d: got valid=%b v=%0d, want valid=%b v=%0d",
                 i + 1, ov[0], dv[0][6:0], vs[i], exp_v[i]);
      end
      for (int d = 0; d < ND; d++) begin
        n_chk++;
        if ({ov[d], so[d], dv[d]} !== {ev[d], es[d], packv(d)}) begin
          n_fail++;
          $display("FAIL gaps_model dut%0d: got %b/%b/%h, want %b/%b/%h",
                   d, ov[d], so[d], dv[d], ev[d], es[d], packv(d));
        end
      end
    end
  endtask

  task automatic test_reset_drop();
    bit         rs [3] = '{0, 1, 0};
    logic [31:0] xs [3] = '{32'h3333_3333, 32'h1414_1414, 32'h1414_1414};
    logic [27:0] exp_v [3] = '{{4{7'd50}}, 28'h0, {4{7'd19}}};
    bit          exp_ov [3] = '{1, 0, 1};
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(rs[i], 1'b1, xs[i]);
      n_chk++;
      if ({ov[0], so[0], dv[0]} !== {exp_ov[i], 4'b0000, exp_v[i]}) begin
        n_fail++;
        $display("FAIL reset_drop step %0d: got valid=%b spk=%b v=%h, want valid=%b spk=0 v=%h",
                 i + 1, ov[0], so[0], dv[0], exp_ov[i], exp_v[i]);
      end
      for (int d = 0; d < ND; d++) begin
        n_chk++;
        if ({ov[d], so[d], dv[d]} !== {ev[d], es[d], packv(d)}) begin
          n_fail++;
          $display("FAIL reset_drop_model dut%0d: got %b/%b/%h, want %b/%b/%h",
                   d, ov[d], so[d], dv[d], ev[d], es[d], packv(d));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x;
    bit          r, v;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N_CH; c++)
        x[c*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 60));
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(r, v, x);
      for (int d = 0; d < ND; d++) begin
        n_chk++;
        if ({ov[d], so[d], dv[d]} !== {ev[d], es[d], packv(d)}) begin
          n_fail++;
          $display("FAIL random_model step %0d dut%0d: got %b/%b/%h, want %b/%b/%h",
                   i, d, ov[d], so[d], dv[d], ev[d], es[d], packv(d));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; spike_in = 32'h0;
    test_reset();
    test_integrate();
    test_saturate();
    test_reset_mode();
    test_gaps();
    test_reset_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
